// File: rtl/fam_arb_pkg.sv
// rtl/fam_arb_pkg.sv - shared request/response types and widths for the multi-tile FAM arbiter
package fam_arb_pkg;

    localparam int fflags_width_lp = 5;
    localparam int instr_width_lp  = 32;
    localparam int data_width_lp   = 32;
    localparam int frm_width_lp    = 3;

    typedef struct packed {
        logic nv;
        logic dz;
        logic of;
        logic uf;
        logic nx;
    } f_flags_s;

    typedef struct packed {
        logic [instr_width_lp-1:0] instr;
        logic [data_width_lp-1:0]  frs1;
        logic [data_width_lp-1:0]  frs2;
        logic [data_width_lp-1:0]  frs3;
        logic [frm_width_lp-1:0]   frm;
    } fam_req_s;

    typedef struct packed {
        logic [data_width_lp-1:0] result;
        f_flags_s                 fflags;
    } fam_resp_s;

    localparam int fam_req_width_lp  = $bits(fam_req_s);
    localparam int fam_resp_width_lp = $bits(fam_resp_s);

    function automatic int req_width(input int instr_w, input int data_w, input int frm_w);
        return instr_w + 3 * data_w + frm_w;
    endfunction

endpackage

// File: rtl/fam_tag_fifo.sv
// rtl/fam_tag_fifo.sv - in-order FIFO of source-channel tags for ops in flight in the FAM unit
module fam_tag_fifo
    import fam_arb_pkg::*;
#(
    parameter int depth_p = 4,
    parameter int width_p = 1,
    localparam int ptr_w_lp = (depth_p > 1) ? $clog2(depth_p) : 1,
    localparam int cnt_w_lp = $clog2(depth_p) + 1
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               push,
    input  logic [width_p-1:0] wr_data,
    input  logic               pop,
    output logic               full,
    output logic               empty,
    output logic [width_p-1:0] head
);

    logic [width_p-1:0]  mem [depth_p];
    logic [ptr_w_lp-1:0] wr_ptr;
    logic [ptr_w_lp-1:0] rd_ptr;
    logic [cnt_w_lp-1:0] count;

    // Pointers wrap naturally because depth_p is a power of two.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) mem[wr_ptr] <= wr_data;
    end

    assign full  = (count == cnt_w_lp'(depth_p));
    assign empty = (count == '0);
    assign head  = mem[rd_ptr];

endmodule

// File: rtl/fam_multi_tile_arbiter.sv
// rtl/fam_multi_tile_arbiter.sv - round-robin issue of tile FAM requests and in-order result steering
// Optional FAM_ARB_STATS_EN adds saturating per-channel issue and full-stall counters.
module fam_multi_tile_arbiter
    import fam_arb_pkg::*;
#(
    parameter int num_chan_p    = 2,
    parameter int instr_width_p = 32,
    parameter int data_width_p  = 32,
    parameter int frm_width_p   = 3,
    parameter int max_out_p     = 4,
    localparam int req_w_lp  = req_width(instr_width_p, data_width_p, frm_width_p),
    localparam int resp_w_lp = data_width_p + fflags_width_lp,
    localparam int chan_w_lp = (num_chan_p > 1) ? $clog2(num_chan_p) : 1
) (
    input  logic                           clk_i,
    input  logic                           reset_i,
    input  logic [num_chan_p-1:0]          v_i,
    input  logic [num_chan_p*req_w_lp-1:0] req_i,
    output logic [num_chan_p-1:0]          ready_o,
    output logic                           fam_v_o,
    output logic [req_w_lp-1:0]            fam_req_o,
    input  logic                           fam_ready_i,
    input  logic                           fam_v_i,
    input  logic [resp_w_lp-1:0]           fam_resp_i,
    output logic                           fam_yumi_o,
    output logic [num_chan_p-1:0]          v_o,
    output logic [resp_w_lp-1:0]           resp_o,
`ifdef FAM_ARB_STATS_EN
    output logic [num_chan_p*32-1:0]       issue_cnt_o,
    output logic [31:0]                    full_stall_cnt_o,
`endif
    input  logic [num_chan_p-1:0]          yumi_i
);

    logic [chan_w_lp-1:0]    rr_ptr;
    logic [chan_w_lp-1:0]    grant;
    logic [chan_w_lp-1:0]    head;
    logic [chan_w_lp:0]      sum;
    logic [2*num_chan_p-1:0] v_dbl;
    logic [num_chan_p-1:0]   v_rot;
    logic                    any_v;
    logic                    full;
    logic                    empty;
    logic                    issue;

    // Rotate so bit 0 is the rr pointer; first set bit is the grant offset.
    assign v_dbl = {v_i, v_i};
    assign v_rot = num_chan_p'(v_dbl >> rr_ptr);

    always_comb begin
        grant = '0;
        any_v = 1'b0;
        sum   = '0;
        for (int i = 0; i < num_chan_p; i++) begin
            if (!any_v && v_rot[i]) begin
                any_v = 1'b1;
                sum   = {1'b0, rr_ptr} + (chan_w_lp+1)'(i);
                grant = (sum >= (chan_w_lp+1)'(num_chan_p)) ?
                        chan_w_lp'(sum - (chan_w_lp+1)'(num_chan_p)) : chan_w_lp'(sum);
            end
        end
    end

    always_comb begin
        fam_req_o = '0;
        ready_o   = '0;
        v_o       = '0;
        for (int i = 0; i < num_chan_p; i++) begin
            if (grant == chan_w_lp'(i)) begin
                fam_req_o  = req_i[i*req_w_lp +: req_w_lp];
                ready_o[i] = any_v && fam_ready_i && !full;
            end
            v_o[i] = fam_v_i && !empty && (head == chan_w_lp'(i));
        end
    end

    assign fam_v_o    = any_v && !full;
    assign issue      = fam_v_o && fam_ready_i;
    assign resp_o     = fam_resp_i;
    assign fam_yumi_o = |(v_o & yumi_i);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            rr_ptr <= '0;
        end else if (issue) begin
            rr_ptr <= (grant == chan_w_lp'(num_chan_p - 1)) ? '0 : grant + 1'b1;
        end
    end

    fam_tag_fifo #(
        .depth_p (max_out_p),
        .width_p (chan_w_lp)
    ) tag_fifo (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .push    (issue),
        .wr_data (grant),
        .pop     (fam_yumi_o),
        .full    (full),
        .empty   (empty),
        .head    (head)
    );

    always_ff @(posedge clk_i) begin
        if (!reset_i) assert (!(fam_v_i && empty));
    end

`ifdef FAM_ARB_STATS_EN
    logic [31:0] issue_cnt [num_chan_p];
    logic [31:0] stall_cnt;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int i = 0; i < num_chan_p; i++) issue_cnt[i] <= '0;
            stall_cnt <= '0;
        end else begin
            for (int i = 0; i < num_chan_p; i++) begin
                if (issue && grant == chan_w_lp'(i) && issue_cnt[i] != '1)
                    issue_cnt[i] <= issue_cnt[i] + 1'b1;
            end
            if (any_v && full && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
        end
    end

    always_comb begin
        issue_cnt_o = '0;
        for (int i = 0; i < num_chan_p; i++) issue_cnt_o[i*32 +: 32] = issue_cnt[i];
    end

    assign full_stall_cnt_o = stall_cnt;
`endif

endmodule

// File: tb/tb_fam_multi_tile_arbiter.sv
// tb/tb_fam_multi_tile_arbiter.sv - scoreboard bench for fam_multi_tile_arbiter (FAM_ARB_STATS_EN optional)
module tb_fam_multi_tile_arbiter;

    localparam int req_w_lp  = 131;
    localparam int resp_w_lp = 37;

    typedef struct {
        logic [1:0]          ch_oh;
        logic [req_w_lp-1:0] req;
    } iss_t;

    typedef struct {
        logic [1:0]           ch_oh;
        logic [resp_w_lp-1:0] resp;
    } res_t;

    logic                  clk = 1'b0;
    logic                  reset_i = 1'b1;
    logic [1:0]            v_i = '0;
    logic [2*req_w_lp-1:0] req_i;
    logic [1:0]            ready_o;
    logic                  fam_v_o;
    logic [req_w_lp-1:0]   fam_req_o;
    logic                  fam_ready_i = 1'b0;
    logic                  fam_v_i = 1'b0;
    logic [resp_w_lp-1:0]  fam_resp_i = '0;
    logic                  fam_yumi_o;
    logic [1:0]            v_o;
    logic [resp_w_lp-1:0]  resp_o;
    logic [1:0]            yumi_i = '0;
`ifdef FAM_ARB_STATS_EN
    logic [63:0]           issue_cnt_o;
    logic [31:0]           full_stall_cnt_o;
`endif

    logic [req_w_lp-1:0] req_c [2];
    iss_t iss_q [$];
    res_t res_q [$];
    iss_t mon_iss;
    res_t mon_res;
    logic exp_yumi;
    int   checks = 0;
    int   errors = 0;

    assign req_i = {req_c[1], req_c[0]};

    always #5 clk = ~clk;

    fam_multi_tile_arbiter dut (
        .clk_i            (clk),
        .reset_i          (reset_i),
        .v_i              (v_i),
        .req_i            (req_i),
        .ready_o          (ready_o),
        .fam_v_o          (fam_v_o),
        .fam_req_o        (fam_req_o),
        .fam_ready_i      (fam_ready_i),
        .fam_v_i          (fam_v_i),
        .fam_resp_i       (fam_resp_i),
        .fam_yumi_o       (fam_yumi_o),
        .v_o              (v_o),
        .resp_o           (resp_o),
`ifdef FAM_ARB_STATS_EN
        .issue_cnt_o      (issue_cnt_o),
        .full_stall_cnt_o (full_stall_cnt_o),
`endif
        .yumi_i           (yumi_i)
    );

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [req_w_lp-1:0] mk_req(input int k, input int c);
        return {32'h0000_0043 + 32'(k * 16 + c), 32'h3F80_0000 + 32'(c),
                32'h4000_0000 + 32'(k), 32'h4040_0000, 3'(c + k)};
    endfunction

    task automatic set_reqs(input int k);
        req_c[0] = mk_req(k, 0);
        req_c[1] = mk_req(k, 1);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        v_i = '0; fam_ready_i = 1'b0; fam_v_i = 1'b0; yumi_i = '0;
        step();
    endtask

    task automatic issue(input logic [1:0] v, input int ch);
        v_i = v; fam_ready_i = 1'b1; fam_v_i = 1'b0; yumi_i = '0;
        iss_q.push_back('{ch_oh: 2'(1 << ch), req: req_c[ch]});
        step();
    endtask

    task automatic ret(input int ch, input logic [resp_w_lp-1:0] resp, input logic [1:0] yumi, input bit first);
        v_i = '0; fam_ready_i = 1'b0; fam_v_i = 1'b1; fam_resp_i = resp; yumi_i = yumi;
        if (first) res_q.push_back('{ch_oh: 2'(1 << ch), resp: resp});
        step();
    endtask

    task automatic stall_cycle(input string name);
        v_i = 2'b11; fam_ready_i = 1'b1; fam_v_i = 1'b0; yumi_i = '0;
        @(negedge clk);
        check({name, "_fam_v"}, fam_v_o, 1'b0);
        check({name, "_ready"}, ready_o, 2'b00);
        step();
    endtask

    task automatic reset_check(input string name);
        reset_i = 1'b1; v_i = '0; fam_ready_i = 1'b0; fam_v_i = 1'b1; yumi_i = 2'b11;
        fam_resp_i = {32'hDEAD_BEEF, 5'b11111};
        @(negedge clk);
        check({name, "_v_o"}, v_o, 2'b00);
        check({name, "_fam_yumi"}, fam_yumi_o, 1'b0);
        check({name, "_fam_v"}, fam_v_o, 1'b0);
        check({name, "_ready"}, ready_o, 2'b00);
        step();
        reset_i = 1'b0; fam_v_i = 1'b0; yumi_i = '0;
        step();
    endtask

    always @(negedge clk) begin
        if (!reset_i) begin
            if (fam_v_o && fam_ready_i) begin
                if (iss_q.size() == 0) begin
                    check("issue_unexpected", fam_v_o, 1'b0);
                end else begin
                    mon_iss = iss_q.pop_front();
                    check("issue_ready", ready_o, mon_iss.ch_oh);
                    check("issue_req", fam_req_o, mon_iss.req);
                end
            end
            if (fam_v_i) begin
                if (res_q.size() == 0) begin
                    check("result_unexpected", v_o, 2'b00);
                end else begin
                    mon_res = res_q[0];
                    exp_yumi = |(mon_res.ch_oh & yumi_i);
                    check("result_v_o", v_o, mon_res.ch_oh);
                    check("result_resp", resp_o, mon_res.resp);
                    check("result_fam_yumi", fam_yumi_o, exp_yumi);
                    if (exp_yumi) void'(res_q.pop_front());
                end
            end
        end
    end

    initial begin
        set_reqs(1);
        reset_check("reset_init");

        // Reset with three ops in flight must drop tags and rr pointer.
        issue(2'b11, 0);
        issue(2'b11, 1);
        issue(2'b11, 0);
        reset_check("reset_mid");

        // Round-robin 0,1,0,1 fills the tag FIFO; fifth cycle blocked.
        set_reqs(2);
        issue(2'b11, 0);
        issue(2'b11, 1);
        issue(2'b11, 0);
        issue(2'b11, 1);
        stall_cycle("full_block");

        // Full with a same-cycle pop still blocks issue.
        set_reqs(3);
        v_i = 2'b11; fam_ready_i = 1'b1; fam_v_i = 1'b1; yumi_i = 2'b01;
        fam_resp_i = {32'h4120_0000, 5'b00000};
        res_q.push_back('{ch_oh: 2'b01, resp: fam_resp_i});
        @(negedge clk);
        check("full_pop_fam_v", fam_v_o, 1'b0);
        check("full_pop_ready", ready_o, 2'b00);
        step();
        issue(2'b11, 0);
        stall_cycle("refull");

        // Backpressure: head held until the owning channel consumes.
        ret(1, {32'h4049_0FDB, 5'b00001}, 2'b00, 1'b1);
        ret(1, {32'h4049_0FDB, 5'b00001}, 2'b00, 1'b0);
        ret(1, {32'h4049_0FDB, 5'b00001}, 2'b00, 1'b0);
        ret(1, {32'h4049_0FDB, 5'b00001}, 2'b10, 1'b0);
        ret(0, {32'hC000_0000, 5'b10000}, 2'b10, 1'b1);
        ret(0, {32'hC000_0000, 5'b10000}, 2'b01, 1'b0);
        ret(1, {32'h7F80_0000, 5'b00100}, 2'b10, 1'b1);
        ret(0, {32'h0000_0001, 5'b00011}, 2'b01, 1'b1);

        // In-order return ch1,ch0,ch1 plus a simultaneous issue and pop.
        set_reqs(4);
        issue(2'b10, 1);
        issue(2'b01, 0);
        issue(2'b10, 1);
        v_i = 2'b01; fam_ready_i = 1'b1; fam_v_i = 1'b1; yumi_i = 2'b10;
        fam_resp_i = {32'h3F80_0000, 5'b00001};
        iss_q.push_back('{ch_oh: 2'b01, req: req_c[0]});
        res_q.push_back('{ch_oh: 2'b10, resp: fam_resp_i});
        step();
        ret(0, {32'h4000_0000, 5'b00000}, 2'b01, 1'b1);
        ret(1, {32'h4040_0000, 5'b01000}, 2'b10, 1'b1);
        ret(0, {32'h4080_0000, 5'b00010}, 2'b01, 1'b1);
        idle();

`ifdef FAM_ARB_STATS_EN
        reset_check("reset_stats");
        set_reqs(5);
        for (int p = 0; p < 3; p++) begin
            issue(2'b11, 0);
            issue(2'b11, 1);
            issue(2'b11, 0);
            issue(2'b11, 1);
            if (p < 2) stall_cycle("stats_stall");
            ret(0, {32'h3F80_0000 + 32'(p), 5'b00000}, 2'b01, 1'b1);
            ret(1, {32'h3F80_0010 + 32'(p), 5'b00001}, 2'b10, 1'b1);
            ret(0, {32'h3F80_0020 + 32'(p), 5'b00000}, 2'b01, 1'b1);
            ret(1, {32'h3F80_0030 + 32'(p), 5'b00001}, 2'b10, 1'b1);
        end
        for (int k = 0; k < 4; k++) issue(2'b01, 0);
        idle();
        check("stats_issue_ch0", issue_cnt_o[31:0], 32'd10);
        check("stats_issue_ch1", issue_cnt_o[63:32], 32'd6);
        check("stats_full_stall", full_stall_cnt_o, 32'd2);
`endif

        check("issue_q_drained", 32'(iss_q.size()), 32'd0);
        check("res_q_drained", 32'(res_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
